alu_result_uart_tx: RTL and testbench

- Read-out end of the ALU datapath: snapshots the ALU result bundle (opcode, doutr, doutz, flag_of) on a start pulse and serializes it as a fixed UART frame (8N1, LSB first) on one TX line.
- The start pulse is the debounced key pulse already used to advance the opcode, or any single-cycle strobe.
- Sits beside the ALU top and drives the board UART pin, giving a host-visible log of every ALU operation.

---
 rtl/alu_result_uart_tx_if.sv | 41 ++++
 rtl/alu_result_uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_alu_result_uart_tx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_uart_tx_if.sv
// Bus between the ALU read-out logger and whoever feeds it: the result bundle
// plus start strobe going in, and the UART line with its status strobes coming out.
interface alu_result_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [3:0]            opcode;
    logic [DATA_WIDTH-1:0] doutr;
    logic                  doutz;
    logic                  flag_of;
    logic                  tx;
    logic                  busy;
    logic                  done;
    logic                  overrun;

    // The ALU side drives the result bundle and the start strobe.
    modport master (
        output start,
        output opcode,
        output doutr,
        output doutz,
        output flag_of,
        input  tx,
        input  busy,
        input  done,
        input  overrun
    );

    // The transmitter samples the bundle and drives the serial line.
    modport slave (
        input  start,
        input  opcode,
        input  doutr,
        input  doutz,
        input  flag_of,
        output tx,
        output busy,
        output done,
        output overrun
    );
endinterface

// File: rtl/alu_result_uart_tx.sv
// ALU result logger: on an accepted start it snapshots the ALU result bundle
// and sends it as an 8N1, LSB-first UART frame of NB+2 bytes:
//   HEADER, {flag_of, doutz, 2'b00, opcode}, then doutr MSB byte first.
// A start that arrives mid-frame is dropped and reported on overrun.
// rst_n is synchronous and active-high despite its name.
module alu_result_uart_tx #(
    parameter int         DATA_WIDTH = 8,
    parameter int         BAUD_DIV   = 434,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_result_uart_tx_if.slave bus
);
    localparam int NB      = (DATA_WIDTH + 7) / 8;
    localparam int NBYTES  = NB + 2;
    localparam int BYTE_W  = $clog2(NBYTES);
    localparam int TIMER_W = $clog2(BAUD_DIV);
    localparam int FRAME_W = 8 * NBYTES;

    localparam logic [BYTE_W-1:0]  LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_next;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_next;
    logic [BYTE_W-1:0]    byte_cnt;
    logic [BYTE_W-1:0]    byte_next;
    logic [7:0]           shift;
    logic [7:0]           shift_next;
    logic                 tx_q;
    logic                 tx_next;
    logic                 done_q;
    logic                 done_next;
    logic                 overrun_q;
    logic                 overrun_next;
    logic                 capture;
    logic                 tick;

    logic [3:0]           snap_opcode;
    logic [DATA_WIDTH-1:0] snap_doutr;
    logic                 snap_doutz;
    logic                 snap_flag_of;

    logic [8*NB-1:0]      result_padded;
    logic [FRAME_W-1:0]   frame;
    logic [BYTE_W-1:0]    following;
    logic [7:0]           following_byte;

    assign tick = (timer == LAST_TICK);

    // Lay the whole frame out as one vector, first byte in the top bits.
    always_comb begin
        result_padded                   = '0;
        result_padded[DATA_WIDTH-1:0]   = snap_doutr;
        frame = {HEADER, snap_flag_of, snap_doutz, 2'b00, snap_opcode, result_padded};
    end

    // Pick out the byte that follows the one currently on the line.
    always_comb begin
        following      = byte_cnt + 1'b1;
        following_byte = 8'hFF;
        for (int k = 0; k < NBYTES; k++) begin
            if (following == BYTE_W'(k)) begin
                following_byte = frame[FRAME_W-1-8*k -: 8];
            end
        end
    end

    // Next-state and next-output logic; tx is computed for the coming cycle so it leaves a flop.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_next     = bit_cnt;
        byte_next    = byte_cnt;
        shift_next   = shift;
        tx_next      = 1'b1;
        done_next    = 1'b0;
        overrun_next = bus.start && (state != IDLE);
        capture      = 1'b0;

        if (state != IDLE) begin
            timer_next = tick ? '0 : timer + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (bus.start) begin
                    capture    = 1'b1;
                    state_next = START_BIT;
                    timer_next = '0;
                    bit_next   = '0;
                    byte_next  = '0;
                    shift_next = HEADER;
                    tx_next    = 1'b0;
                end
            end

            START_BIT: begin
                tx_next = 1'b0;
                if (tick) begin
                    state_next = DATA_BITS;
                    bit_next   = '0;
                    tx_next    = shift[0];
                end
            end

            DATA_BITS: begin
                tx_next = shift[0];
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP_BIT;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_cnt + 1'b1;
                        shift_next = {1'b0, shift[7:1]};
                        tx_next    = shift[1];
                    end
                end
            end

            STOP_BIT: begin
                tx_next = 1'b1;
                if (tick) begin
                    if (byte_cnt == LAST_BYTE) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = START_BIT;
                        byte_next  = following;
                        shift_next = following_byte;
                        tx_next    = 1'b0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset wins over any start.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bit_cnt   <= bit_next;
            byte_cnt  <= byte_next;
            shift     <= shift_next;
            tx_q      <= tx_next;
            done_q    <= done_next;
            overrun_q <= overrun_next;
        end
    end

    // Snapshot the result bundle on the accepting edge so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            snap_opcode  <= '0;
            snap_doutr   <= '0;
            snap_doutz   <= 1'b0;
            snap_flag_of <= 1'b0;
        end else if (capture) begin
            snap_opcode  <= bus.opcode;
            snap_doutr   <= bus.doutr;
            snap_doutz   <= bus.doutz;
            snap_flag_of <= bus.flag_of;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for the ALU result UART logger: an 8-bit and a 12-bit instance, both at
// four clocks per bit. Expected frames come from a byte-level model of the frame
// layout; the line is sampled every cycle and decoded at bit centres.
module tb_alu_result_uart_tx;
    localparam int BAUD  = 4;
    localparam int LIMIT = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_bytes [6];
    int         exp_count;
    logic       tx_samp [LIMIT];

    alu_result_uart_tx_if #(.DATA_WIDTH(8))  bus8 ();
    alu_result_uart_tx_if #(.DATA_WIDTH(12)) bus12 ();

    alu_result_uart_tx #(.DATA_WIDTH(8), .BAUD_DIV(BAUD), .HEADER(8'hA5)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    alu_result_uart_tx #(.DATA_WIDTH(12), .BAUD_DIV(BAUD), .HEADER(8'hA5)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus12.slave)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case a wait never resolves.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not reach the end");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic getTx(input int sel);
        return (sel != 0) ? bus12.tx : bus8.tx;
    endfunction

    function automatic logic getBusy(input int sel);
        return (sel != 0) ? bus12.busy : bus8.busy;
    endfunction

    function automatic logic getDone(input int sel);
        return (sel != 0) ? bus12.done : bus8.done;
    endfunction

    function automatic logic getOverrun(input int sel);
        return (sel != 0) ? bus12.overrun : bus8.overrun;
    endfunction

    task automatic setStart(input int sel, input logic v);
        if (sel != 0) bus12.start = v;
        else          bus8.start  = v;
    endtask

    task automatic setOpDout(input int sel, input logic [3:0] op, input logic [31:0] r);
        if (sel != 0) begin
            bus12.opcode = op;
            bus12.doutr  = r[11:0];
        end else begin
            bus8.opcode = op;
            bus8.doutr  = r[7:0];
        end
    endtask

    // Frame model: header, flag byte, then the result split into bytes MSB first.
    function automatic void buildExpected(input int dw, input logic [3:0] op, input logic [31:0] r,
                                          input logic z, input logic of);
        int          nb;
        logic [31:0] masked;
        nb        = (dw + 7) / 8;
        masked    = r & ((32'd1 << dw) - 32'd1);
        exp_count = nb + 2;
        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = {of, z, 2'b00, op};
        for (int i = 0; i < nb; i++) begin
            exp_bytes[2+i] = 8'((masked >> (8 * (nb - 1 - i))) & 32'hFF);
        end
    endfunction

    // Called on a falling edge: presents the bundle with a one-cycle start.
    task automatic applyStimulus(input int sel, input logic [3:0] op, input logic [31:0] r,
                                 input logic z, input logic of);
        setOpDout(sel, op, r);
        if (sel != 0) begin
            bus12.doutz   = z;
            bus12.flag_of = of;
        end else begin
            bus8.doutz   = z;
            bus8.flag_of = of;
        end
        setStart(sel, 1'b1);
        @(negedge clk);
        setStart(sel, 1'b0);
    endtask

    // Samples the line once per cycle while busy; optionally fires a stray start or
    // changes the inputs. Returns on the first falling edge where busy is low.
    task automatic recordFrame(input int sel, input int overrun_at, input int change_at,
                               output int busy_len, output int ov_count, output int done_seen);
        busy_len  = 0;
        ov_count  = 0;
        done_seen = 0;
        for (int i = 0; i < LIMIT; i++) tx_samp[i] = 1'bx;
        for (int s = 0; s < LIMIT; s++) begin
            if (getOverrun(sel)) ov_count++;
            if (!getBusy(sel)) begin
                done_seen = int'(getDone(sel));
                break;
            end
            tx_samp[s] = getTx(sel);
            busy_len++;
            setStart(sel, s == overrun_at);
            if (s == change_at) setOpDout(sel, 4'h0, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        setStart(sel, 1'b0);
    endtask

    // Decode recorded samples at bit centres and compare with the model bytes.
    task automatic decodeFrame(input string tag);
        int         base;
        logic [7:0] got;
        for (int k = 0; k < exp_count; k++) begin
            base = 10 * k * BAUD;
            checkOutput($sformatf("%s_start%0d", tag, k), 32'(tx_samp[base + BAUD/2]), 32'd0);
            for (int b = 0; b < 8; b++) got[b] = tx_samp[base + (1 + b) * BAUD + BAUD/2];
            checkOutput($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(exp_bytes[k]));
            checkOutput($sformatf("%s_stop%0d", tag, k), 32'(tx_samp[base + 9 * BAUD + BAUD/2]), 32'd1);
        end
    endtask

    initial begin
        int          busy_len;
        int          ov_count;
        int          done_seen;
        int          done_hits;
        int          sel;
        int          ov_at;
        logic [3:0]  r_op;
        logic [31:0] r_val;
        logic        r_z;
        logic        r_of;

        bus8.start  = 1'b0; bus8.opcode  = '0; bus8.doutr  = '0; bus8.doutz  = 1'b0; bus8.flag_of  = 1'b0;
        bus12.start = 1'b0; bus12.opcode = '0; bus12.doutr = '0; bus12.doutz = 1'b0; bus12.flag_of = 1'b0;

        // Reset for two cycles.
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_tx",      32'(bus8.tx),       32'd1);
        checkOutput("reset_busy",    32'(bus8.busy),     32'd0);
        checkOutput("reset_done",    32'(bus8.done),     32'd0);
        checkOutput("reset_overrun", 32'(bus8.overrun),  32'd0);
        checkOutput("reset_tx12",    32'(bus12.tx),      32'd1);
        checkOutput("reset_busy12",  32'(bus12.busy),    32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame.
        $display("[TB] basic frame");
        buildExpected(8, 4'h3, 32'h5A, 1'b0, 1'b1);
        applyStimulus(0, 4'h3, 32'h5A, 1'b0, 1'b1);
        checkOutput("basic_tx_fall", 32'(bus8.tx),   32'd0);
        checkOutput("basic_busy_on", 32'(bus8.busy), 32'd1);
        recordFrame(0, -1, -1, busy_len, ov_count, done_seen);
        checkOutput("basic_busy_len", 32'(busy_len),  32'd120);
        checkOutput("basic_done",     32'(done_seen), 32'd1);
        checkOutput("basic_overrun",  32'(ov_count),  32'd0);
        decodeFrame("basic");
        @(negedge clk);
        checkOutput("basic_done_once", 32'(bus8.done), 32'd0);
        repeat (3) @(negedge clk);

        // Inputs changed right after acceptance must not reach the line.
        $display("[TB] snapshot");
        applyStimulus(0, 4'h3, 32'h5A, 1'b0, 1'b1);
        recordFrame(0, -1, 0, busy_len, ov_count, done_seen);
        checkOutput("snap_busy_len", 32'(busy_len), 32'd120);
        decodeFrame("snap");
        repeat (3) @(negedge clk);

        // Stray start mid-frame, then a start in the done cycle.
        $display("[TB] overrun and back-to-back");
        buildExpected(8, 4'h9, 32'h3C, 1'b1, 1'b0);
        applyStimulus(0, 4'h9, 32'h3C, 1'b1, 1'b0);
        recordFrame(0, 50, -1, busy_len, ov_count, done_seen);
        checkOutput("ovr_count",    32'(ov_count),  32'd1);
        checkOutput("ovr_busy_len", 32'(busy_len),  32'd120);
        checkOutput("ovr_done",     32'(done_seen), 32'd1);
        decodeFrame("ovr");
        buildExpected(8, 4'h6, 32'hC3, 1'b0, 1'b0);
        applyStimulus(0, 4'h6, 32'hC3, 1'b0, 1'b0);
        checkOutput("b2b_tx_fall", 32'(bus8.tx),   32'd0);
        checkOutput("b2b_busy_on", 32'(bus8.busy), 32'd1);
        recordFrame(0, -1, -1, busy_len, ov_count, done_seen);
        checkOutput("b2b_busy_len", 32'(busy_len), 32'd120);
        checkOutput("b2b_overrun",  32'(ov_count), 32'd0);
        decodeFrame("b2b");
        repeat (3) @(negedge clk);

        // Reset during the fourth data bit of byte 1 abandons the frame.
        $display("[TB] reset mid-frame");
        applyStimulus(0, 4'h3, 32'h5A, 1'b0, 1'b1);
        repeat (57) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_tx",   32'(bus8.tx),   32'd1);
        checkOutput("midrst_busy", 32'(bus8.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus8.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        done_hits = 0;
        repeat (120) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) done_hits++;
        end
        checkOutput("midrst_quiet", 32'(done_hits), 32'd0);
        buildExpected(8, 4'h0, 32'h00, 1'b1, 1'b0);
        applyStimulus(0, 4'h0, 32'h00, 1'b1, 1'b0);
        recordFrame(0, -1, -1, busy_len, ov_count, done_seen);
        checkOutput("postrst_busy_len", 32'(busy_len), 32'd120);
        decodeFrame("postrst");
        repeat (3) @(negedge clk);

        // Wide result on the 12-bit instance.
        $display("[TB] wide result");
        buildExpected(12, 4'hF, 32'hABC, 1'b0, 1'b0);
        applyStimulus(1, 4'hF, 32'hABC, 1'b0, 1'b0);
        checkOutput("wide_tx_fall", 32'(bus12.tx), 32'd0);
        recordFrame(1, -1, -1, busy_len, ov_count, done_seen);
        checkOutput("wide_busy_len", 32'(busy_len),  32'd160);
        checkOutput("wide_done",     32'(done_seen), 32'd1);
        decodeFrame("wide");
        repeat (3) @(negedge clk);

        // Randomized frames on both instances, some with a stray start.
        $display("[TB] random frames");
        for (int n = 0; n < 10; n++) begin
            sel   = int'($urandom_range(0, 1));
            r_op  = 4'($urandom);
            r_val = $urandom;
            r_z   = 1'($urandom);
            r_of  = 1'($urandom);
            ov_at = ($urandom_range(0, 1) != 0) ? int'($urandom_range(5, 100)) : -1;
            buildExpected((sel != 0) ? 12 : 8, r_op, r_val, r_z, r_of);
            applyStimulus(sel, r_op, r_val, r_z, r_of);
            recordFrame(sel, ov_at, -1, busy_len, ov_count, done_seen);
            checkOutput($sformatf("rnd%0d_busy_len", n), 32'(busy_len), (sel != 0) ? 32'd160 : 32'd120);
            checkOutput($sformatf("rnd%0d_overrun", n), 32'(ov_count), (ov_at >= 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rnd%0d_done", n), 32'(done_seen), 32'd1);
            decodeFrame($sformatf("rnd%0d", n));
            repeat (2) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
